// File: rtl/computer_pkg.sv
// Shared definitions for the parametrised register-file CPU: opcodes, FSM states
// and instruction-field extraction helpers that work for any DATA_W / REG_AW.
package computer_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_OUT  = 4'h9;
  localparam logic [3:0] OP_IN   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_ILL  = 4'hF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5
  } state_e;

  // Instructions are zero-extended into this container so one set of helpers
  // serves every parameterisation.
  localparam int MAX_INSTR_W = 64;
  typedef logic [MAX_INSTR_W-1:0] instr_t;

  function automatic logic [3:0] f_op(input instr_t instr, input int data_w, input int reg_aw);
    return 4'(instr >> (data_w + 2 * reg_aw));
  endfunction

  function automatic logic [7:0] f_rd(input instr_t instr, input int data_w, input int reg_aw);
    return 8'((instr >> (data_w + reg_aw)) & ((instr_t'(1) << reg_aw) - instr_t'(1)));
  endfunction

  function automatic logic [7:0] f_rb(input instr_t instr, input int data_w, input int reg_aw);
    return 8'((instr >> data_w) & ((instr_t'(1) << reg_aw) - instr_t'(1)));
  endfunction

  function automatic instr_t f_imm(input instr_t instr, input int data_w);
    return instr & ((instr_t'(1) << data_w) - instr_t'(1));
  endfunction

endpackage

// File: rtl/computer_alu.sv
// Combinational ALU: arithmetic/logic result plus zero and carry/borrow flags.
module computer_alu
  import computer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      // The extra top bit goes to 1 exactly when a < b, i.e. the borrow.
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        c      = a[DATA_W-1];
      end
      OP_MOV: result = b;
      default: result = '0;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/computer_param.sv
// Multi-cycle register-file CPU with loadable program RAM, I/O ports, flags,
// conditional jumps and illegal-opcode trapping; 4 cycles per instruction.
module computer_param
  import computer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 4,
  parameter int PROG_DEPTH = 256,
  parameter int NUM_OPORTS = 2,
  localparam int REG_AW    = $clog2(NUM_REGS),
  localparam int PC_W      = $clog2(PROG_DEPTH),
  localparam int INSTR_W   = 4 + 2 * REG_AW + DATA_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         prog_we,
  input  logic [PC_W-1:0]              prog_addr,
  input  logic [INSTR_W-1:0]           prog_data,
  input  logic [DATA_W-1:0]            iport,
  output logic [NUM_OPORTS*DATA_W-1:0] oport,
  output logic [PC_W-1:0]              iaddr,
  output logic [2:0]                   state,
  output logic                         halted,
  output logic                         error
);

  logic [INSTR_W-1:0] mem [PROG_DEPTH];
  logic [INSTR_W-1:0] ram_rdata;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic [DATA_W-1:0]  oport_q [NUM_OPORTS];
  logic [DATA_W-1:0]  oport_d [NUM_OPORTS];
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic               z_q, z_d, c_q, c_d, br_q, br_d, err_q, err_d;

  logic [3:0]         op_x;
  logic [REG_AW-1:0]  rd_x, rd_f, rb_f;
  logic [DATA_W-1:0]  imm_x;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_z, alu_c;

  // Program RAM: writes allowed in any state; a same-cycle write to the
  // fetched address returns the old word.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
    if (state_q == FETCH) ram_rdata <= mem[pc_q];
  end

  // rd/rb for the register read come from the freshly fetched word; the
  // execute/writeback fields come from the latched instruction.
  assign rd_f  = REG_AW'(f_rd(instr_t'(ram_rdata), DATA_W, REG_AW));
  assign rb_f  = REG_AW'(f_rb(instr_t'(ram_rdata), DATA_W, REG_AW));
  assign op_x  = f_op(instr_t'(ir_q), DATA_W, REG_AW);
  assign rd_x  = REG_AW'(f_rd(instr_t'(ir_q), DATA_W, REG_AW));
  assign imm_x = DATA_W'(f_imm(instr_t'(ir_q), DATA_W));

  computer_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_x),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    regs_d  = regs_q;
    oport_d = oport_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    br_d    = br_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) state_d = FETCH;
      FETCH: state_d = DECODE;
      DECODE: begin
        ir_d    = ram_rdata;
        a_d     = regs_q[rd_f];
        b_d     = regs_q[rb_f];
        state_d = EXECUTE;
      end
      EXECUTE: begin
        state_d = WRITEBACK;
        br_d    = 1'b0;
        case (op_x)
          OP_LDI: res_d = imm_x;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
            res_d = alu_res;
            z_d   = alu_z;
            c_d   = alu_c;
          end
          OP_MOV:  res_d = alu_res;
          OP_IN:   res_d = iport;
          OP_JMP:  br_d  = 1'b1;
          OP_JZ:   br_d  = z_q;
          OP_JC:   br_d  = c_q;
          OP_HALT: state_d = HALTED;
          OP_ILL: begin
            err_d   = 1'b1;
            state_d = HALTED;
          end
          default: ;
        endcase
      end
      WRITEBACK: begin
        if (op_x inside {OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                         OP_SHL, OP_MOV, OP_IN})
          regs_d[rd_x] = res_q;
        // Out-of-range port numbers simply match no port.
        if (op_x == OP_OUT)
          for (int k = 0; k < NUM_OPORTS; k++)
            if ({1'b0, imm_x} == (DATA_W + 1)'(k)) oport_d[k] = a_q;
        pc_d    = br_q ? imm_x[PC_W-1:0] : pc_q + PC_W'(1);
        state_d = FETCH;
      end
      HALTED: if (start) begin
        state_d = FETCH;
        pc_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      for (int k = 0; k < NUM_OPORTS; k++) oport_q[k] <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      br_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      regs_q  <= regs_d;
      oport_q <= oport_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
      br_q    <= br_d;
      err_q   <= err_d;
    end
  end

  for (genvar k = 0; k < NUM_OPORTS; k++) begin : g_oport
    assign oport[k*DATA_W +: DATA_W] = oport_q[k];
  end

  assign iaddr  = pc_q;
  assign state  = state_q;
  assign halted = (state_q == HALTED);
  assign error  = err_q;

endmodule

// File: tb/tb_computer_param.sv
// Bench for computer_param: instruction-level reference model checked every
// cycle, directed programs with literal expectations, and a wide-datapath run.
module tb_computer_param;

  localparam int PD = 256;
  localparam int NP = 2;

  logic        clk;
  logic        reset, start, prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic [7:0]  iport;
  logic [15:0] oport;
  logic [7:0]  iaddr;
  logic [2:0]  state;
  logic        halted, error;

  logic        w_reset, w_start, w_prog_we;
  logic [7:0]  w_prog_addr;
  logic [25:0] w_prog_data;
  logic [15:0] w_iport;
  logic [31:0] w_oport;
  logic [7:0]  w_iaddr;
  logic [2:0]  w_state;
  logic        w_halted, w_error;

  int nchecks = 0;
  int nerrs   = 0;

  computer_param dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .iport(iport),
    .oport(oport), .iaddr(iaddr), .state(state), .halted(halted), .error(error)
  );

  computer_param #(.DATA_W(16), .NUM_REGS(8)) dut_wide (
    .clk(clk), .reset(w_reset), .start(w_start), .prog_we(w_prog_we),
    .prog_addr(w_prog_addr), .prog_data(w_prog_data), .iport(w_iport),
    .oport(w_oport), .iaddr(w_iaddr), .state(w_state), .halted(w_halted),
    .error(w_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  int          mregs [4];
  bit          mz, mc, merr, model_ok = 1'b0;
  int          mstate, mpc, pend_out, pend_pc;
  logic [7:0]  pend_val;
  logic [7:0]  moport [NP];
  logic [15:0] mmem [PD];
  logic [15:0] minstr;

  task automatic model_exec();
    int op, rd, rb, imm, a, b, r;
    bit flags;
    op = int'(minstr[15:12]); rd = int'(minstr[11:10]);
    rb = int'(minstr[9:8]);   imm = int'(minstr[7:0]);
    a = mregs[rd]; b = mregs[rb]; r = 0; flags = 1'b0;
    pend_out = -1; pend_pc = (mpc + 1) % PD; mstate = 4;
    case (op)
      1:  mregs[rd] = imm;
      2:  begin r = (a + b) % 256; mc = (a + b) > 255; flags = 1'b1; end
      3:  begin r = (a - b + 256) % 256; mc = a < b; flags = 1'b1; end
      4:  begin r = a & b; mc = 1'b0; flags = 1'b1; end
      5:  begin r = a | b; mc = 1'b0; flags = 1'b1; end
      6:  begin r = a ^ b; mc = 1'b0; flags = 1'b1; end
      7:  begin r = (a * 2) % 256; mc = a > 127; flags = 1'b1; end
      8:  mregs[rd] = b;
      9:  if (imm < NP) begin pend_out = imm; pend_val = 8'(a); end
      10: mregs[rd] = int'(iport);
      11: pend_pc = imm;
      12: if (mz) pend_pc = imm;
      13: if (mc) pend_pc = imm;
      14: mstate = 5;
      15: begin merr = 1'b1; mstate = 5; end
      default: ;
    endcase
    if (flags) begin mregs[rd] = r; mz = (r == 0); end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mstate = 0; mpc = 0; mz = 1'b0; mc = 1'b0; merr = 1'b0; model_ok = 1'b1;
      for (int i = 0; i < 4; i++) mregs[i] = 0;
      for (int i = 0; i < NP; i++) moport[i] = 8'h00;
    end else begin
      case (mstate)
        0: if (start) mstate = 1;
        1: begin minstr = mmem[mpc]; mstate = 2; end
        2: mstate = 3;
        3: model_exec();
        4: begin
          if (pend_out >= 0) moport[pend_out] = pend_val;
          mpc = pend_pc; mstate = 1;
        end
        5: if (start) begin mstate = 1; mpc = 0; end
        default: ;
      endcase
    end
    if (prog_we) mmem[prog_addr] = prog_data;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("state",  64'(state),  64'(mstate));
      chk("iaddr",  64'(iaddr),  64'(mpc));
      chk("halted", 64'(halted), 64'(mstate == 5));
      chk("error",  64'(error),  64'(merr));
      chk("oport",  64'(oport),  64'({moport[1], moport[0]}));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] pq [$];
  logic [7:0]  obs [$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rb, input int imm);
    return {4'(op), 2'(rd), 2'(rb), 8'(imm)};
  endfunction

  function automatic logic [25:0] wenc(input int op, input int rd, input int rb, input int imm);
    return {4'(op), 3'(rd), 3'(rb), 16'(imm)};
  endfunction

  function automatic logic [15:0] rand_instr();
    int op = int'($urandom_range(15, 0));
    int imm = int'($urandom_range(255, 0));
    if (op == 15 && $urandom_range(3, 0) != 0) op = 0;
    if (op == 9) imm = int'($urandom_range(3, 0));
    if (op >= 11 && op <= 13) imm = int'($urandom_range(19, 0));
    return enc(op, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), imm);
  endfunction

  task automatic load();
    for (int i = 0; i < pq.size(); i++) begin
      prog_we = 1'b1; prog_addr = 8'(i); prog_data = pq[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic run(input int budget, output int cyc);
    logic [7:0] last;
    obs.delete();
    last = oport[7:0];
    start = 1'b1; tick(); start = 1'b0; cyc = 1;
    while (!halted && cyc < budget) begin
      tick(); cyc++;
      if (oport[7:0] !== last) begin obs.push_back(oport[7:0]); last = oport[7:0]; end
    end
    chk("run_reaches_halt", 64'(halted), 64'd1);
  endtask

  task automatic reload();
    reset = 1'b1; load(); tick(); reset = 1'b0;
  endtask

  initial begin
    int cyc;
    bit seen_ffff;
    reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; iport = '0;
    w_reset = 1'b1; w_start = 1'b0; w_prog_we = 1'b0; w_prog_addr = '0; w_prog_data = '0;
    w_iport = '0;
    tick(); tick();
    for (int i = 0; i < PD; i++) begin
      prog_we = 1'b1; prog_addr = 8'(i); prog_data = enc(14, 0, 0, 0); tick();
    end
    prog_we = 1'b0;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_oport", 64'(oport), 64'd0);
    chk("reset_iaddr", 64'(iaddr), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);

    // LDI/LDI/ADD/OUT/HALT
    pq = '{enc(1,0,0,5), enc(1,1,0,3), enc(2,0,1,0), enc(9,0,0,1), enc(14,0,0,0)};
    reload();
    run(200, cyc);
    chk("p1_cycles", 64'(cyc), 64'd20);
    chk("p1_oport", 64'(oport), 64'h0800);
    chk("p1_iaddr", 64'(iaddr), 64'd4);

    // Reset in the EXECUTE cycle of the ADD, then rerun the intact program
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    chk("mid_state_exec", 64'(state), 64'd3);
    chk("mid_iaddr_add", 64'(iaddr), 64'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_reset_state", 64'(state), 64'd0);
    chk("mid_reset_oport", 64'(oport), 64'd0);
    chk("mid_reset_iaddr", 64'(iaddr), 64'd0);
    run(200, cyc);
    chk("rerun_cycles", 64'(cyc), 64'd20);
    chk("rerun_oport", 64'(oport), 64'h0800);

    // Carry out of 0xFF+1, JC taken, then JZ taken
    pq = '{enc(1,2,0,8'h5A), enc(9,2,0,0), enc(1,0,0,8'hFF), enc(1,1,0,1),
           enc(2,0,1,0), enc(13,0,0,8), enc(9,1,0,1), enc(14,0,0,0),
           enc(9,0,0,0), enc(12,0,0,11), enc(14,0,0,0), enc(14,0,0,0)};
    reload();
    run(300, cyc);
    chk("jc_oport", 64'(oport), 64'h0000);
    chk("jc_iaddr", 64'(iaddr), 64'd11);
    chk("jc_obs_count", 64'(obs.size()), 64'd2);

    // Countdown loop
    pq = '{enc(1,0,0,3), enc(1,1,0,1), enc(9,0,0,0), enc(3,0,1,0),
           enc(12,0,0,6), enc(11,0,0,2), enc(14,0,0,0)};
    reload();
    run(400, cyc);
    chk("cd_obs_count", 64'(obs.size()), 64'd3);
    if (obs.size() == 3) begin
      chk("cd_obs0", 64'(obs[0]), 64'd3);
      chk("cd_obs1", 64'(obs[1]), 64'd2);
      chk("cd_obs2", 64'(obs[2]), 64'd1);
    end
    chk("cd_iaddr", 64'(iaddr), 64'd6);

    // Illegal opcode trap
    pq = '{enc(15,0,0,0)};
    reload();
    run(50, cyc);
    chk("ill_cycles", 64'(cyc), 64'd4);
    chk("ill_error", 64'(error), 64'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("ill_restart_state", 64'(state), 64'd1);
    chk("ill_restart_iaddr", 64'(iaddr), 64'd0);
    chk("ill_error_sticky", 64'(error), 64'd1);
    repeat (4) tick();
    chk("ill_halted_again", 64'(halted), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("ill_reset_clears", 64'(error), 64'd0);

    // OUT to a missing port, then IN/OUT
    iport = 8'hA5;
    pq = '{enc(1,0,0,8'h11), enc(9,0,0,5), enc(10,1,0,0), enc(9,1,0,0), enc(14,0,0,0)};
    reload();
    run(200, cyc);
    chk("io_oport", 64'(oport), 64'h00A5);
    chk("io_error", 64'(error), 64'd0);

    // Randomised programs, inputs, restarts, resets and live program writes
    pq.delete();
    for (int i = 0; i < 20; i++) pq.push_back(rand_instr());
    reload();
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(149, 0) == 0);
      start     = ($urandom_range(7, 0) == 0);
      iport     = 8'($urandom);
      prog_we   = ($urandom_range(15, 0) == 0);
      prog_addr = 8'($urandom_range(19, 0));
      prog_data = rand_instr();
      tick();
    end
    reset = 1'b0; start = 1'b0; prog_we = 1'b0;

    // 16-bit datapath, 8 registers: 0xFFFF + 1 wraps with carry
    begin
      logic [25:0] wq [$];
      wq = '{wenc(1,0,0,16'hFFFF), wenc(9,0,0,1), wenc(1,7,0,1), wenc(2,0,7,0),
             wenc(13,0,0,6), wenc(14,0,0,0), wenc(9,0,0,1), wenc(14,0,0,0)};
      for (int i = 0; i < wq.size(); i++) begin
        w_prog_we = 1'b1; w_prog_addr = 8'(i); w_prog_data = wq[i]; tick();
      end
      w_prog_we = 1'b0; w_reset = 1'b0;
      w_start = 1'b1; tick(); w_start = 1'b0;
      seen_ffff = 1'b0;
      for (int i = 0; i < 100 && !w_halted; i++) begin
        tick();
        if (w_oport[31:16] == 16'hFFFF) seen_ffff = 1'b1;
      end
      chk("wide_halted", 64'(w_halted), 64'd1);
      chk("wide_saw_ffff", 64'(seen_ffff), 64'd1);
      chk("wide_oport", 64'(w_oport), 64'h0);
      chk("wide_iaddr_jc", 64'(w_iaddr), 64'd7);
      chk("wide_error", 64'(w_error), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule

// File: doc/computer_param.md
Name: computer_param

Overview:
Parametrised successor to the fixed 8-bit `computer` core. It is a multi-cycle register-file CPU with configurable data width, register count, program depth and output-port count. It adds an internal program RAM loaded over a write port, an input port, ALU status flags, conditional jumps, start/halt control, and illegal-opcode trapping. It sits at top level under the system testbench, which drives `clk`/`reset` and observes `oport`.

Parameters:
DATA_W, 8, datapath, register, immediate and per-port width
NUM_REGS, 4, register-file entries (power of 2, >=2); REG_AW = clog2(NUM_REGS)
PROG_DEPTH, 256, program words (power of 2, <= 2**DATA_W); PC_W = clog2(PROG_DEPTH)
NUM_OPORTS, 2, output ports (>=1)
Derived: INSTR_W = 4 + 2*REG_AW + DATA_W

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  level-sampled; leaves IDLE or HALTED
prog_we  in  1  program RAM write enable
prog_addr  in  PC_W  program write address
prog_data  in  INSTR_W  program write data
iport  in  DATA_W  input port, sampled by IN
oport  out  NUM_OPORTS*DATA_W  output ports; port k = bits [k*DATA_W +: DATA_W]
iaddr  out  PC_W  current PC
state  out  3  FSM state encoding
halted  out  1  high in HALTED
error  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (one edge, synchronous): registers, flags Z/C, PC, oport, error and instruction register all cleared to 0; state=IDLE. Program RAM is NOT cleared. Reset wins over every other event, including mid-instruction.
- Instruction fields: opcode=[INSTR_W-1 -:4], operand_1 (rd)=next REG_AW bits, operand_2 (rb)=next REG_AW bits, imm=[DATA_W-1:0].
- Program RAM: synchronous write on prog_we in any state. Synchronous read at PC in FETCH. A same-cycle write to the fetched address returns the old data.
- FSM: IDLE -> FETCH when start=1. Then FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH, i.e. exactly 4 cycles per instruction. HALTED -> FETCH when start=1, with PC reset to 0 and registers/flags/oport kept.
- FETCH: RAM read. DECODE: latch instruction, read rd and rb. EXECUTE: ALU result and flags computed and registered; branch decided. WRITEBACK: register/oport write; PC <= branch target, or else PC+1 mod PROG_DEPTH (wraps silently).
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd=imm.
  - 2 ADD: rd=rd+rb, C=carry-out.
  - 3 SUB: rd=rd-rb, C=borrow.
  - 4 AND, 5 OR, 6 XOR: C=0.
  - 7 SHL: rd=rd<<1, C=old msb.
  - 8 MOV: rd=rb.
  - 9 OUT: oport[imm]=rd. If imm>=NUM_OPORTS, no write and no error.
  - A IN: rd=iport, sampled in EXECUTE.
  - B JMP: PC=imm[PC_W-1:0].
  - C JZ: jump if Z.
  - D JC: jump if C.
  - E HALT.
  - F illegal.
- Flags: opcodes 2-7 update Z (result==0) and C. All other opcodes leave the flags unchanged. Arithmetic wraps modulo 2**DATA_W.
- HALT: EXECUTE -> HALTED. PC holds the HALT address; no writeback.
- Illegal opcode: error<=1 (sticky until reset), EXECUTE -> HALTED.
- oport registers update at the WRITEBACK edge and hold until the next OUT to the same port or reset.
- A rd==rb source is read before the write (read-before-write).

Decomposition:
- Shared package `computer_pkg`: opcode localparams (OP_NOP..OP_ILL), state enum IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5, and field-extraction helpers parameterised by DATA_W/REG_AW.
- One sub-module `computer_alu` (combinational; inputs a, b, op; outputs result, z, c; parameter DATA_W).
- The FSM, register file and program RAM stay in `computer_param`.

Test Plan:
- Defaults; load {LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0,1; HALT} with reset high, then pulse start -> oport[1]=0x08 after 16 cycles, oport[0]=0, halted=1 at cycle 20, iaddr=4.
- {LDI r0,0xFF; LDI r1,1; ADD r0,r1; JC 6; …; 6: OUT r0,0; HALT} -> r0=0, Z=1, C=1, jump taken, oport[0]=0x00, halted.
- Countdown loop {LDI r0,3; LDI r1,1; 2: OUT r0,0; SUB r0,r1; JZ 6; JMP 2; 6: HALT} -> oport[0] sequence 3,2,1, then halted with Z=1.
- Opcode 0xF at address 0 -> error=1 and halted after 3 cycles in FETCH/DECODE/EXECUTE; start restarts from PC 0 with error still 1; reset clears error.
- OUT with imm=5 (NUM_OPORTS=2) -> all oport unchanged, error=0. IN with iport=0xA5 then OUT 0 -> oport[0]=0xA5.
- Reset asserted during EXECUTE of ADD -> next cycle state=IDLE, registers/oport zero; program intact, so re-running produces identical results. Repeat with DATA_W=16, NUM_REGS=8 to confirm 0xFFFF+1 wraps to 0 with C=1.
